// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter onto one single-ported memory
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DSTREAK_MAX    = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              arb_err
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam int SW = $clog2(DSTREAK_MAX + 1);

    state_t        state;
    logic          owner_d;
    logic [SW-1:0] streak;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          streak_full;
    logic          pick_d;
    logic          grant_d;
    logic          grant_if;
    logic          resp;
    logic          timeout_hit;
    logic          done;
    logic [31:0]   resp_data;

    // Data normally wins; a full streak lets a waiting fetch through once.
    assign streak_full = (streak == SW'(DSTREAK_MAX));
    assign pick_d      = d_req && !(if_req && streak_full);
    assign grant_d     = rst_n && (state == IDLE) && pick_d;
    assign grant_if    = rst_n && (state == IDLE) && !pick_d && if_req;
    assign if_gnt      = grant_if;
    assign d_gnt       = grant_d;

    assign resp      = (state == WAIT) && mem_rvalid;
    assign done      = resp || timeout_hit;
    assign resp_data = resp ? mem_rdata : 32'h0;
    assign if_rvalid = done && !owner_d;
    assign d_rvalid  = done && owner_d;
    assign if_rdata  = if_rvalid ? resp_data : if_rdata_q;
    assign d_rdata   = d_rvalid ? resp_data : d_rdata_q;

    // A request abandoned by the watchdog is withdrawn so memory never accepts it.
    assign mem_req = (state == REQ) && !timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign timeout_hit = (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign arb_err     = err_q || timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE || timeout_hit) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            streak     <= '0;
            mem_we     <= 1'b0;
            mem_funct3 <= 3'b000;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= resp_data;
            end
            if (d_rvalid) begin
                d_rdata_q <= resp_data;
            end
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d    <= 1'b1;
                        mem_we     <= d_we;
                        mem_funct3 <= d_funct3;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        state      <= REQ;
                        if (!if_req) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (grant_if) begin
                        owner_d    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_funct3 <= 3'b010;
                        mem_addr   <= if_addr;
                        mem_wdata  <= 32'h0;
                        streak     <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (mem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
